// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Bits needed to count 0 .. value-1.
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/div32x32_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface div32x32_seq_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, a, b,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/div32x32_arith.sv
// Restoring-division datapath: partial remainder R, quotient/dividend shifter Q,
// captured divisor, and the one-bit-per-step subtract/restore.
module div32x32_arith
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_nxt,
   output logic [WIDTH-1:0] r_nxt
);

   // R is always < b after a step, so only WIDTH bits need storing; the
   // WIDTH+1-bit partial remainder exists as the shifted value r_sh.
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH:0]   diff;

   // Shift {R,Q} left, trial-subtract b, restore on borrow.
   always_comb begin
      r_sh  = {r_reg, q_reg[WIDTH-1]};
      q_sh  = {q_reg[WIDTH-2:0], 1'b0};
      diff  = r_sh - {1'b0, b_reg};
      r_nxt = r_sh[WIDTH-1:0];
      q_nxt = q_sh;
      if (!diff[WIDTH]) begin
         r_nxt = diff[WIDTH-1:0];
         q_nxt = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Operand capture on load, one quotient bit per step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_reg <= '0;
         q_reg <= '0;
         b_reg <= '0;
      end else if (load) begin
         r_reg <= '0;
         q_reg <= a;
         b_reg <= b;
      end else if (step) begin
         r_reg <= r_nxt;
         q_reg <= q_nxt;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/div32x32_seq.sv
// Sequential unsigned divider: control FSM, bit counter, result registers.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; operands captured on the accepting edge
//  CALC  | one quotient bit per cycle; a zero divisor spends a single
//        | cycle here with the datapath frozen
//  DONE  | done pulse; results were written on the edge into this state
module div32x32_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   div32x32_seq_if.slave bus
);

   localparam int             CW       = clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [1:0]     ST_IDLE  = IDLE;
   localparam logic [1:0]     ST_CALC  = CALC;
   localparam logic [1:0]     ST_DONE  = DONE;

   logic [1:0]       state;
   logic [CW-1:0]    counter;
   logic             dbz_cap;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             accept;
   logic             step;
   logic             last;
   logic             b_zero;
   logic [WIDTH-1:0] q_cur;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] r_nxt;

   assign b_zero = (bus.b == '0);
   assign accept = (state == ST_IDLE) && bus.start;
   assign step   = (state == ST_CALC) && !dbz_cap;
   assign last   = (state == ST_CALC) && (counter == CNT_LAST);

   div32x32_arith #(.WIDTH(WIDTH)) u_arith (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .step  (step),
      .a     (bus.a),
      .b     (bus.b),
      .q     (q_cur),
      .q_nxt (q_nxt),
      .r_nxt (r_nxt)
   );

   // State sequencing and bit counter. A zero divisor preloads the counter at
   // its terminal value so it still takes one CALC cycle before DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         counter <= '0;
         dbz_cap <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state   <= ST_CALC;
                  counter <= b_zero ? CNT_LAST : '0;
                  dbz_cap <= b_zero;
               end
            end
            ST_CALC: begin
               counter <= counter + 1'b1;
               if (counter == CNT_LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Results are written on the edge into DONE and held until the next one.
   // With b==0 the datapath never stepped, so Q still holds the dividend.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else if (last) begin
         if (dbz_cap) begin
            quotient_q  <= '1;
            remainder_q <= q_cur;
            dbz_q       <= 1'b1;
         end else begin
            quotient_q  <= q_nxt;
            remainder_q <= r_nxt;
            dbz_q       <= 1'b0;
         end
      end
   end

   assign bus.busy        = (state != ST_IDLE);
   assign bus.done        = (state == ST_DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32x32_seq.sv
// Directed and random checks of the sequential divider.
module tb_div32x32_seq;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   div32x32_seq_if bus ();

   div32x32_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at #1 after a rising edge with the divider idle. Returns results
   // sampled in the done cycle, the cycle index of done (start cycle = 0), and
   // the done level one cycle later.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dbz, output int lat, output logic done_after);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      q   = bus.quotient;
      r   = bus.remainder;
      dbz = bus.div_by_zero;
      @(posedge clk); #1;
      done_after = bus.done;
   endtask

   property p_done_one_cycle;
      @(posedge clk) disable iff (!reset) bus.done |=> !bus.done;
   endproperty

   a_done_one_cycle: assert property (p_done_one_cycle)
      else begin
         errors++;
         $display("FAIL done_width: done high two cycles in a row");
      end

   initial begin
      logic [31:0] q, r, eq, er;
      logic        dbz, edbz, dn_after;
      int          lat, pulses, first_done, second_done;

      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
      vecs[3]  = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
      vecs[4]  = '{32'd0,          32'd3,          32'd0,          32'd0,          1'b0};
      vecs[5]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1};
      vecs[6]  = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0};
      vecs[7]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
      vecs[8]  = '{32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1,          1'b0};
      vecs[9]  = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0};
      vecs[10] = '{32'h1234_5678,  32'd1000,       32'd305419,     32'd896,        1'b0};
      vecs[11] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_q",    bus.quotient,  32'd0);
      check("rst_r",    bus.remainder, 32'd0);
      check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i].a, vecs[i].b, q, r, dbz, lat, dn_after);
         check($sformatf("vec%0d_q", i),   q,            vecs[i].q);
         check($sformatf("vec%0d_r", i),   r,            vecs[i].r);
         check($sformatf("vec%0d_dbz", i), 32'(dbz),     32'(vecs[i].dbz));
         check($sformatf("vec%0d_lat", i), 32'(lat),     (vecs[i].b == 0) ? 32'd2 : 32'd33);
         check($sformatf("vec%0d_pulse", i), 32'(dn_after), 32'd0);
         check($sformatf("vec%0d_hold", i), bus.quotient, vecs[i].q);
      end

      // Start pulse while busy is ignored
      bus.a = 32'd1000; bus.b = 32'd10; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      pulses = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (bus.done) pulses++;
         if (cyc == 5) begin
            check("busy_c5", 32'(bus.busy), 32'd1);
            bus.a = 32'd7; bus.b = 32'd7; bus.start = 1'b1;
         end
         if (cyc == 6) bus.start = 1'b0;
         @(posedge clk); #1;
      end
      check("ign_q",      bus.quotient,  32'd100);
      check("ign_r",      bus.remainder, 32'd0);
      check("ign_pulses", 32'(pulses),   32'd1);
      check("ign_idle",   32'(bus.busy), 32'd0);

      // Reset mid-division clears everything
      run_div(32'd1234, 32'd0, q, r, dbz, lat, dn_after);
      bus.a = 32'd1000; bus.b = 32'd10; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check("mrst_q",    bus.quotient,  32'd0);
      check("mrst_r",    bus.remainder, 32'd0);
      check("mrst_dbz",  32'(bus.div_by_zero), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_div(32'd81, 32'd9, q, r, dbz, lat, dn_after);
      check("post_q",   q,         32'd9);
      check("post_r",   r,         32'd0);
      check("post_lat", 32'(lat),  32'd33);

      // Start held high: back-to-back divisions, one accept per IDLE visit
      bus.a = 32'd20; bus.b = 32'd4; bus.start = 1'b1;
      first_done  = 0;
      second_done = 0;
      for (int cyc = 0; cyc <= 80 && second_done == 0; cyc++) begin
         if (cyc > 0 && bus.done) begin
            if (first_done == 0) first_done = cyc;
            else second_done = cyc;
         end
         if (second_done == 0) begin
            @(posedge clk); #1;
         end
      end
      bus.start = 1'b0;
      check("b2b_first",  32'(first_done),  32'd33);
      check("b2b_second", 32'(second_done), 32'd67);
      check("b2b_q",      bus.quotient,     32'd5);
      @(posedge clk); #1;

      // Random operands against a reference model
      for (int i = 0; i < 200; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         case (i % 10)
            0:       rb = 32'd0;
            1:       rb = 32'd1;
            2:       rb = $urandom_range(1, 255);
            default: rb = $urandom;
         endcase
         if (rb == 0) begin
            eq = 32'hFFFF_FFFF; er = ra; edbz = 1'b1;
         end else begin
            eq = ra / rb; er = ra % rb; edbz = 1'b0;
         end
         run_div(ra, rb, q, r, dbz, lat, dn_after);
         check($sformatf("rnd%0d_q %h/%h", i, ra, rb), q, eq);
         check($sformatf("rnd%0d_r %h/%h", i, ra, rb), r, er);
         check($sformatf("rnd%0d_dbz", i), 32'(dbz), 32'(edbz));
         check($sformatf("rnd%0d_lat", i), 32'(lat), (rb == 0) ? 32'd2 : 32'd33);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
